disco_responder: RTL
====================

# disco_responder

Disk-side responder for block transfers between main memory and the disk. The memory controller initiates each transfer with a one-cycle request carrying direction, base disk address and word count. This block models seek latency, then streams words in or out of its internal disk array and signals completion. It replaces a plain disk array at the disk end of the store-to-disk / load-from-disk path.

## Interface
- ADDR_W, 15, disk word-address width; array depth 2^ADDR_W words
- DATA_W, 16, word width
- LATENCY, 4, seek cycles between request acceptance and first transfer cycle; legal range 1..255
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  transfer request; sampled only in IDLE
- op  in  1  1 = write to disk (store), 0 = read from disk (load); sampled with req
- addr  in  ADDR_W  base disk address; sampled with req
- len  in  8  word count; 0 encodes 256; sampled with req
- wdata  in  DATA_W  write word
- wvalid  in  1  wdata valid
- wready  out  1  responder accepts a write word this cycle
- rdata  out  DATA_W  read word
- rvalid  out  1  rdata valid, one word per cycle, no backpressure
- busy  out  1  transfer in progress (state ≠ IDLE)
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SEEK, XFER, DONE.
- IDLE: on req=1, latch op, addr into pointer, len (0→256) into remaining-count; go to SEEK; load seek counter with LATENCY-1.
- SEEK: decrement each cycle; at 0 go to XFER.
- XFER write: wready=1. Each cycle with wvalid=1, array[pointer] ← wdata, pointer+1, count-1. Word accepted with count=1 → DONE. wvalid=0 stalls indefinitely; no timeout.
- XFER read: each cycle, registered read of array[pointer], pointer+1, count-1. Read issued with count=1 → DONE. rvalid/rdata registered, one cycle behind the issue.
- DONE: done=1 for one cycle → IDLE.
- Pointer arithmetic is modulo 2^ADDR_W. A transfer crossing the top address wraps to 0.
- req outside IDLE, including during DONE, is ignored and not queued.
- wvalid outside XFER-write is ignored. The array is never written outside XFER-write.
- Reset, async and at any time: state IDLE. busy, done, wready, rvalid = 0. rdata = 0. Counters and pointer = 0. The array is not cleared. Words already written by an aborted transfer remain.

## Timing
- Edge 0 = edge sampling req in IDLE. busy=1 from edge 0.
- SEEK covers the cycles after edges 0..LATENCY-1. XFER is entered at edge LATENCY.
- Write: wready is combinational from state and is high from edge LATENCY. With wvalid held high, words are accepted at edges LATENCY+1..LATENCY+n. done=1 in the cycle after edge LATENCY+n. busy falls at edge LATENCY+n+1.
- Read: rvalid=1 in the n cycles after edges LATENCY+1..LATENCY+n. Each word is rdata = array[addr+k] for k = 0..n-1. done=1 coincides with the last rvalid cycle. busy falls at edge LATENCY+n+1.
- Minimum request-to-request spacing: LATENCY+n+1 cycles, since the next req is accepted on the edge after DONE.

## Test plan
- Reset: rst_n=0 asserted mid-cycle → busy, done, wready, rvalid, rdata all 0 immediately, without waiting for a clock edge.
- Write then read, LATENCY=4: write addr=0x0010, len=3, data 0xAAAA/0xBBBB/0xCCCC with wvalid held high → wready high from edge 4, done in the cycle after edge 7. Read back the same range → rvalid cycles after edges 5,6,7 with those values, done with the third word.
- Stall: write len=2 with wvalid low for 5 XFER cycles, then high → exactly 2 words stored, done one cycle after the 2nd accept, busy high throughout the stall.
- Wrap and len=0: write addr=0x7FFF, len=2 → words land at 0x7FFF and 0x0000. Read len=0 from 0x0000 → exactly 256 rvalid cycles.
- Ignored req: pulse req at edges 2 and 3 and during DONE of an active transfer → no state change, no extra done. The next req accepted in IDLE behaves normally.
- Reset mid-transfer: rst_n low after 2 of 4 words written, then released → IDLE. Reading back shows the 2 written words and the old contents elsewhere.

Source files
------------

// File: rtl/disco_responder_if.sv
// Transfer request / data channel between the memory controller (master)
// and the disk-side responder (slave).
interface disco_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;

  modport master (
    output req, op, addr, len, wdata, wvalid,
    input  wready, rdata, rvalid, busy, done
  );

  modport slave (
    input  req, op, addr, len, wdata, wvalid,
    output wready, rdata, rvalid, busy, done
  );
endinterface

// File: rtl/disco_responder.sv
// Disk-side block-transfer responder: seek delay, then streams words into or
// out of an internal disk array and pulses done at the end of the burst.
module disco_responder #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input logic              clk,
  input logic              rst_n,
  disco_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] SEEK_INIT = 8'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_op;
  logic [ADDR_W-1:0] r_ptr;
  logic [8:0]        r_count;
  logic [7:0]        r_seek;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic w_busy;
  logic w_done;
  logic w_wready;
  logic w_wr_en;
  logic w_rd_en;
  logic w_step;
  logic w_accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) w_next = S_SEEK;
        else         w_next = S_IDLE;
      end
      S_SEEK: begin
        if (r_seek == 8'd0) w_next = S_XFER;
        else                w_next = S_SEEK;
      end
      S_XFER: begin
        if (w_step && (r_count == 9'd1)) w_next = S_DONE;
        else                             w_next = S_XFER;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output and datapath-enable decode from the current state.
  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_wready = 1'b0;
    w_wr_en  = 1'b0;
    w_rd_en  = 1'b0;
    case (r_state)
      S_IDLE: w_busy = 1'b0;
      S_SEEK: w_busy = 1'b1;
      S_XFER: begin
        w_busy   = 1'b1;
        w_wready = r_op;
        w_wr_en  = r_op & bus.wvalid;
        w_rd_en  = ~r_op;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  assign w_step   = w_wr_en | w_rd_en;
  assign w_accept = (r_state == S_IDLE) & bus.req;

  // Request capture, seek countdown and burst pointer/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 1'b0;
      r_ptr   <= {ADDR_W{1'b0}};
      r_count <= 9'd0;
      r_seek  <= 8'd0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_ptr   <= bus.addr;
      r_count <= (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
      r_seek  <= SEEK_INIT;
    end else if (r_state == S_SEEK) begin
      if (r_seek != 8'd0) r_seek <= r_seek - 8'd1;
      else                r_seek <= r_seek;
    end else if (w_step) begin
      // Pointer wraps naturally at the top of the array.
      r_ptr   <= r_ptr + ADDR_W'(1);
      r_count <= r_count - 9'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // Registered read port: word appears one cycle after its issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_rvalid <= w_rd_en;
      if (w_rd_en) r_rdata <= r_mem[r_ptr];
      else         r_rdata <= r_rdata;
    end
  end

  // Disk array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_ptr] <= bus.wdata;
  end

  assign bus.wready = w_wready;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;

endmodule
